// File: rtl/line_drawer_param_if.sv
// Request/pixel-stream bundle between a line requester and line_drawer_param.
// The slave modport is the drawing engine; the master modport is the requester/consumer.
interface line_drawer_param_if #(
    parameter int XW      = 9,
    parameter int YW      = 8,
    parameter int COLOR_W = 3
);
    logic               start;
    logic [XW-1:0]      x0_in;
    logic [XW-1:0]      x1_in;
    logic [YW-1:0]      y0_in;
    logic [YW-1:0]      y1_in;
    logic [COLOR_W-1:0] color_in;
    logic               busy;
    logic               pix_valid;
    logic               pix_ready;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               done;

    modport slave (
        input  start, x0_in, x1_in, y0_in, y1_in, color_in, pix_ready,
        output busy, pix_valid, pix_x, pix_y, pix_color, done
    );

    modport master (
        output start, x0_in, x1_in, y0_in, y1_in, color_in, pix_ready,
        input  busy, pix_valid, pix_x, pix_y, pix_color, done
    );
endinterface

// File: rtl/line_drawer_param.sv
// Any-octant Bresenham line engine emitting one pixel per cycle on a valid/ready stream.
// Optional feature macro: LINE_CLIP_EN (suppress pixels outside SCREEN_W x SCREEN_H).
module line_drawer_param #(
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic               clk,
    input  logic               reset,
    line_drawer_param_if.slave bus
);
    localparam int CW = (XW > YW) ? XW : YW;
    localparam int EW = CW + 2;
    localparam logic [CW-1:0] CW_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] EW_ZERO = {EW{1'b0}};
`ifdef LINE_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ORDER = 3'd2,
        S_INIT  = 3'd3,
        S_DRAW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      x0_q, x0_d, y0_q, y0_d;
    logic [CW-1:0]      x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]      x_q, x_d, y_q, y_d;
    logic [CW-1:0]      dx_q, dx_d, dy_q, dy_d;
    logic [EW-1:0]      err_q, err_d;
    logic               steep_q, steep_d;
    logic               ydown_q, ydown_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               busy_q, busy_d;
    logic               pix_valid_q, pix_valid_d;
    logic               done_q, done_d;
    logic [XW-1:0]      pix_x_q, pix_x_d;
    logic [YW-1:0]      pix_y_q, pix_y_d;

    logic [CW-1:0]      dx_s;
    logic [EW-1:0]      err_sum_s;
    logic               advance_s;
    logic [XW-1:0]      px_s;
    logic [YW-1:0]      py_s;
    logic               hide_s;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    function automatic logic off_screen(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return (int'(px) >= SCREEN_W) || (int'(py) >= SCREEN_H);
    endfunction

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= CW_ZERO;
            y0_q        <= CW_ZERO;
            x1_q        <= CW_ZERO;
            y1_q        <= CW_ZERO;
            x_q         <= CW_ZERO;
            y_q         <= CW_ZERO;
            dx_q        <= CW_ZERO;
            dy_q        <= CW_ZERO;
            err_q       <= EW_ZERO;
            steep_q     <= 1'b0;
            ydown_q     <= 1'b0;
            color_q     <= {COLOR_W{1'b0}};
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pix_x_q     <= {XW{1'b0}};
            pix_y_q     <= {YW{1'b0}};
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            steep_q     <= steep_d;
            ydown_q     <= ydown_d;
            color_q     <= color_d;
            busy_q      <= busy_d;
            pix_valid_q <= pix_valid_d;
            done_q      <= done_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
        end
    end

    // Next state and datapath stepping; err is kept as a two's-complement vector.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        steep_d   = steep_q;
        ydown_d   = ydown_q;
        color_d   = color_q;
        dx_s      = x1_q - x0_q;
        err_sum_s = err_q + {2'b00, dy_q};
        // A suppressed (clipped) pixel never waits for the consumer.
        advance_s = bus.pix_ready || !pix_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x0_d    = CW'(bus.x0_in);
                    y0_d    = CW'(bus.y0_in);
                    x1_d    = CW'(bus.x1_in);
                    y1_d    = CW'(bus.y1_in);
                    color_d = bus.color_in;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                steep_d = abs_diff(y1_q, y0_q) > abs_diff(x1_q, x0_q);
                if (steep_d) begin
                    x0_d = y0_q;
                    y0_d = x0_q;
                    x1_d = y1_q;
                    y1_d = x1_q;
                end else begin
                    x0_d = x0_q;
                    y0_d = y0_q;
                    x1_d = x1_q;
                    y1_d = y1_q;
                end
                state_d = S_ORDER;
            end
            S_ORDER: begin
                if (x0_q > x1_q) begin
                    x0_d = x1_q;
                    y0_d = y1_q;
                    x1_d = x0_q;
                    y1_d = y0_q;
                end else begin
                    x0_d = x0_q;
                    y0_d = y0_q;
                    x1_d = x1_q;
                    y1_d = y1_q;
                end
                state_d = S_INIT;
            end
            S_INIT: begin
                dx_d    = dx_s;
                dy_d    = abs_diff(y1_q, y0_q);
                err_d   = EW_ZERO - {3'b000, dx_s[CW-1:1]};
                ydown_d = !(y0_q < y1_q);
                x_d     = x0_q;
                y_d     = y0_q;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (advance_s) begin
                    if (x_q == x1_q) begin
                        state_d = S_DONE;
                    end else begin
                        x_d = x_q + CW_ONE;
                        if (!err_sum_s[EW-1] && (err_sum_s != EW_ZERO)) begin
                            y_d   = ydown_q ? (y_q - CW_ONE) : (y_q + CW_ONE);
                            err_d = err_sum_s - {2'b00, dx_q};
                        end else begin
                            err_d = err_sum_s;
                        end
                    end
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values are computed from the coming state so that they leave flops.
    always_comb begin
        px_s   = steep_d ? y_d[XW-1:0] : x_d[XW-1:0];
        py_s   = steep_d ? x_d[YW-1:0] : y_d[YW-1:0];
        hide_s = CLIP_ON && off_screen(px_s, py_s);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_DRAW) begin
            pix_valid_d = !hide_s;
            pix_x_d     = px_s;
            pix_y_d     = py_s;
        end else begin
            pix_valid_d = 1'b0;
            pix_x_d     = pix_x_q;
            pix_y_d     = pix_y_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.pix_color = color_q;
    assign bus.done      = done_q;

endmodule

// File: doc/line_drawer_param.md
# line_drawer_param

Parametrised Bresenham line engine for the VGA drawing path. It accepts arbitrary endpoints in any octant and steps the major axis one pixel per cycle. Each pixel is emitted on a valid/ready stream that feeds the frame-buffer writer. It replaces the fixed-width, first-octant-only datapath/control pair with a single self-contained block.

## Interface
Parameters:
- `XW`, 9: x coordinate width (unsigned).
- `YW`, 8: y coordinate width (unsigned).
- `COLOR_W`, 3: colour width.
- `SCREEN_W`, 320: visible width, used only by the clip option.
- `SCREEN_H`, 240: visible height, used only by the clip option.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a line; sampled in IDLE only.
- `x0_in`, `x1_in` in XW: endpoint x values.
- `y0_in`, `y1_in` in YW: endpoint y values.
- `color_in` in COLOR_W: line colour.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is left.
- `pix_valid` out 1: pixel present on `pix_x`/`pix_y`/`pix_color`.
- `pix_ready` in 1: consumer accepts the pixel.
- `pix_x` out XW, `pix_y` out YW, `pix_color` out COLOR_W: pixel data.
- `done` out 1: one-cycle pulse after the last pixel transfers.

## Operation
- Internal coordinate width is CW = max(XW,YW). The error register is signed, CW+2 bits. All other math is unsigned CW.
- States:
  - IDLE: `start`=1 latches all inputs and goes to SETUP.
  - SETUP: compute steep = |y1−y0| > |x1−x0|. If steep, swap x and y of both endpoints. Goes to ORDER.
  - ORDER: if x0 > x1, swap the endpoints.
  - INIT: dx = x1−x0; dy = |y1−y0|; err = −(dx>>1); ystep = +1 if y0<y1, else −1; x = x0, y = y0. Goes to DRAW.
  - DRAW: present pixel (steep ? (y,x) : (x,y)). On transfer, the pixel is the last if x == x1, and the state goes to DONE. Otherwise: x += 1; err += dy; if err > 0 then y += ystep and err −= dx. The comparison uses the updated err.
  - DONE: `done`=1 for one cycle, then IDLE.
- A transfer occurs when `pix_valid` && `pix_ready` are both high.
- While `pix_valid`=1 and `pix_ready`=0, the pixel outputs and all internal state hold.
- A line emits exactly max(|Δx|,|Δy|)+1 pixels. The start point is emitted first after reordering, i.e. the lower major-axis endpoint.
- Degenerate point line (x0=x1, y0=y1): exactly one pixel.
- `start` in any state other than IDLE is ignored. Inputs may change freely once the block has left IDLE.
- `pix_color` equals the latched `color_in` for the whole line.

## Timing
- Reset values: `busy`=0, `pix_valid`=0, `done`=0, `pix_x`/`pix_y`/`pix_color`=0. State = IDLE and all internal registers are 0.
- Reset asserted mid-line aborts immediately. No `done` is produced. The block accepts `start` again on the first edge after reset deasserts.
- Cycle sequence: `start` is sampled at edge E0. SETUP, ORDER and INIT each take one cycle. `pix_valid` is first high after edge E3.
- Latency is 3 cycles from `start` to the first pixel. Throughput is 1 pixel/cycle with `pix_ready` held high.
- `done` is high in the cycle after the last transfer edge. `busy` drops together with `done` falling, so `busy` is still high during DONE.
- `pix_valid` deasserts on the same edge as the last transfer and is never high outside DRAW.

## Configuration
- `LINE_CLIP_EN` defined: a pixel with x ≥ SCREEN_W or y ≥ SCREEN_H is suppressed.
  - `pix_valid` stays low for it, and DRAW advances one step per cycle regardless of `pix_ready`.
  - The final-pixel rule and `done` are unchanged. A fully off-screen line produces no pixels but still pulses `done`.
- `LINE_CLIP_EN` undefined: every computed pixel is presented. SCREEN_W and SCREEN_H are unused.

## Test plan
- Horizontal line: (0,0)→(4,0), ready=1 → pixels x=0..4, y=0 on 5 consecutive cycles starting E3; `done` in the cycle after the fifth transfer.
- Steep reversed line: (2,5)→(0,0) → exactly (0,0),(0,1),(1,2),(1,3),(2,4),(2,5) in that order.
- Backpressure: (0,0)→(7,3) with `pix_ready` low for 3 cycles at the 3rd pixel → pixel (2,1) held stable for 3 cycles; all 8 pixels delivered with no loss or duplication.
- Point line plus ignored start: (10,10)→(10,10) with `start` re-pulsed during SETUP → a single pixel (10,10), one `done`, no second line.
- Reset mid-line: (0,0)→(50,20), `reset` after the 10th pixel → all outputs 0 asynchronously, no `done`; a new line (1,1)→(3,1) then runs normally.
- Clip (LINE_CLIP_EN, SCREEN_W=320): (318,0)→(322,0), ready=1 → only x=318,319 delivered; `done` 5 cycles after the first DRAW cycle.
